mul_issue_ctrl: RTL and testbench

Issue/writeback controller between the execute-stage M-extension decode and the 32x32 iterative multiplier. Accepts one RV32M multiply request (MUL/MULH/MULHSU/MULHU) over a valid/ready handshake, drives the multiplier's operand/signedness/start inputs, tracks its busy/valid outputs, selects the low or high 32 bits of the 64-bit product, and returns the result with the destination register tag. A one-entry product cache and a zero-operand fast path skip the multiplier when possible.

---
 rtl/mul_issue_ctrl.sv | 178 +++++++++++++++++
 tb/tb_mul_issue_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: issues RV32M multiply requests to an iterative 32x32 multiplier and
// returns the selected product word, with a one-entry product cache and a zero fast path.
module mul_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter bit CACHE_EN       = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_op_a,
    input  logic [31:0] req_op_b,
    input  logic [4:0]  req_rd,
    input  logic        flush,
    output logic [31:0] mul_rs1,
    output logic [31:0] mul_rs2,
    output logic        mul_rs1_signed,
    output logic        mul_rs2_signed,
    output logic        mul_start,
    input  logic [63:0] mul_result,
    input  logic        mul_valid,
    input  logic        mul_busy,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        resp_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_RESP, S_DRAIN
    } state_t;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] tmo_cnt;
    logic             busy_seen;
    logic             is_mul_q;

    logic             c_vld;
    logic [31:0]      c_a, c_b;
    logic             c_sa, c_sb;
    logic [63:0]      c_prod;

    logic req_is_mul, req_rs1_s, req_rs2_s, req_illegal, req_zero, req_hit, req_fast;
    logic accept, mul_done, tmo_hit;

    function automatic logic [31:0] sel_word(input logic [63:0] prod, input logic is_mul);
        return is_mul ? prod[31:0] : prod[63:32];
    endfunction

    always_comb begin
        req_is_mul  = (req_funct3 == 3'b000);
        req_rs1_s   = (req_funct3[1:0] != 2'b11);
        req_rs2_s   = ~req_funct3[1];
        req_illegal = req_funct3[2];
        req_zero    = (req_op_a == 32'd0) || (req_op_b == 32'd0);
        // The low product word is the same for any signedness, so MUL ignores it on a hit.
        req_hit     = CACHE_EN && c_vld && (req_op_a == c_a) && (req_op_b == c_b)
                      && (req_is_mul || ((req_rs1_s == c_sa) && (req_rs2_s == c_sb)));
        req_fast    = req_illegal || req_zero || req_hit;
        accept      = (state == S_IDLE) && req_valid && !flush;
        mul_done    = mul_valid && !mul_busy;
        tmo_hit     = (tmo_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = req_fast ? S_RESP : S_START;
            end
            S_START: begin
                state_nxt = flush ? S_DRAIN : S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // A stale mul_valid from the previous op is ignored until busy is seen.
                if (flush)         state_nxt = S_DRAIN;
                else if (mul_busy) state_nxt = S_WAIT_DONE;
                else if (tmo_hit)  state_nxt = S_RESP;
            end
            S_WAIT_DONE: begin
                if (mul_done)     state_nxt = flush ? S_IDLE : S_RESP;
                else if (flush)   state_nxt = S_DRAIN;
                else if (tmo_hit) state_nxt = S_RESP;
            end
            S_RESP: begin
                if (flush || resp_ready) state_nxt = S_IDLE;
            end
            S_DRAIN: begin
                if ((busy_seen && mul_done) || tmo_hit) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = rst && (state == S_IDLE);
        mul_start  = (state == S_START);
        resp_valid = (state == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_cnt        <= '0;
            busy_seen      <= 1'b0;
            is_mul_q       <= 1'b0;
            mul_rs1        <= 32'd0;
            mul_rs2        <= 32'd0;
            mul_rs1_signed <= 1'b0;
            mul_rs2_signed <= 1'b0;
            resp_data      <= 32'd0;
            resp_rd        <= 5'd0;
            resp_err       <= 1'b0;
            c_vld          <= 1'b0;
            c_a            <= 32'd0;
            c_b            <= 32'd0;
            c_sa           <= 1'b0;
            c_sb           <= 1'b0;
            c_prod         <= 64'd0;
        end else begin
            if (state == S_WAIT_BUSY || state == S_WAIT_DONE || state == S_DRAIN)
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            else
                tmo_cnt <= '0;

            if (state == S_IDLE) busy_seen <= 1'b0;
            else if (mul_busy)   busy_seen <= 1'b1;

            if (accept) begin
                resp_rd  <= req_rd;
                is_mul_q <= req_is_mul;
                if (req_illegal) begin
                    resp_data <= 32'd0;
                    resp_err  <= 1'b1;
                end else if (req_zero) begin
                    resp_data <= 32'd0;
                    resp_err  <= 1'b0;
                end else if (req_hit) begin
                    resp_data <= sel_word(c_prod, req_is_mul);
                    resp_err  <= 1'b0;
                end else begin
                    // Operands stay here untouched until the next START, covering DRAIN too.
                    mul_rs1        <= req_op_a;
                    mul_rs2        <= req_op_b;
                    mul_rs1_signed <= req_rs1_s;
                    mul_rs2_signed <= req_rs2_s;
                end
            end

            if (state == S_WAIT_DONE && mul_done && !flush) begin
                resp_data <= sel_word(mul_result, is_mul_q);
                resp_err  <= 1'b0;
                if (CACHE_EN) begin
                    c_vld  <= 1'b1;
                    c_a    <= mul_rs1;
                    c_b    <= mul_rs2;
                    c_sa   <= mul_rs1_signed;
                    c_sb   <= mul_rs2_signed;
                    c_prod <= mul_result;
                end
            end else if ((state == S_WAIT_BUSY || state == S_WAIT_DONE) && state_nxt == S_RESP) begin
                resp_data <= 32'd0;
                resp_err  <= 1'b1;
            end

            if (flush) c_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl: directed plus randomized requests against a behavioural product model,
// with a timed multiplier stub standing in for the iterative multiplier.
module tb_mul_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_op_a, req_op_b;
    logic [4:0]  req_rd;
    logic        flush;
    logic [31:0] mul_rs1, mul_rs2;
    logic        mul_rs1_signed, mul_rs2_signed;
    logic        mul_start;
    logic [63:0] mul_result;
    logic        mul_valid, mul_busy;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_err;

    int tests = 0;
    int fails = 0;

    // Reference cache state, kept from the rules rather than the DUT
    bit          cache_v = 1'b0;
    logic [31:0] cache_a, cache_b;
    bit          cache_sa, cache_sb;
    bit          never_busy = 1'b0;
    logic [31:0] last_a = 32'h1, last_b = 32'h1;

    always #5 clk = ~clk;

    mul_issue_ctrl #(.TIMEOUT_CYCLES(64), .CACHE_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
        .req_op_a(req_op_a), .req_op_b(req_op_b), .req_rd(req_rd),
        .flush(flush),
        .mul_rs1(mul_rs1), .mul_rs2(mul_rs2),
        .mul_rs1_signed(mul_rs1_signed), .mul_rs2_signed(mul_rs2_signed),
        .mul_start(mul_start), .mul_result(mul_result),
        .mul_valid(mul_valid), .mul_busy(mul_busy),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_rd(resp_rd), .resp_err(resp_err)
    );

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                             input bit sa, input bit sb);
        logic signed [63:0] xa, xb;
        xa = sa ? {{32{a[31]}}, a} : {32'd0, a};
        xb = sb ? {{32{b[31]}}, b} : {32'd0, b};
        return xa * xb;
    endfunction

    // Multiplier stub: busy from 2 cycles after start for 17 cycles; valid stays high
    // (stale) until the next op raises busy.
    logic        stub_active = 1'b0;
    int          stub_c = 0;
    logic [63:0] stub_pend = 64'd0, stub_res = 64'd0;
    logic        stub_have = 1'b0;

    always_ff @(posedge clk) begin
        if (mul_start) begin
            stub_active <= 1'b1;
            stub_c      <= 0;
            stub_pend   <= ref_prod(mul_rs1, mul_rs2, mul_rs1_signed, mul_rs2_signed);
        end else if (stub_active) begin
            stub_c <= stub_c + 1;
            if (stub_c == 17) begin
                stub_active <= 1'b0;
                stub_res    <= stub_pend;
                stub_have   <= 1'b1;
            end
        end
    end

    assign mul_busy   = !never_busy && stub_active && (stub_c >= 1);
    assign mul_valid  = stub_have && !mul_busy;
    assign mul_result = stub_res;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                          input logic [4:0] rd, input int stall, input bit flush_resp);
        bit sa, sb, hit, fast, tmo, got;
        logic [63:0] prod;
        logic [31:0] exp_data;
        bit exp_err;
        int n, starts, start_cyc;
        sa   = (f3[1:0] != 2'b11);
        sb   = !f3[1];
        prod = ref_prod(a, b, sa, sb);
        hit  = cache_v && a == cache_a && b == cache_b && (f3 == 3'b000 || (sa == cache_sa && sb == cache_sb));
        fast = f3[2] || a == 32'd0 || b == 32'd0 || hit;
        tmo  = !fast && never_busy;
        exp_err  = f3[2] || tmo;
        exp_data = exp_err ? 32'd0 : (f3 == 3'b000 ? prod[31:0] : prod[63:32]);

        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_op_a = a; req_op_b = b; req_funct3 = f3; req_rd = rd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_op_a = $urandom; req_op_b = $urandom; req_rd = 5'($urandom);
        n = 0; starts = 0; start_cyc = 0; got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            chk("req_ready_busy", req_ready, 0);
            if (mul_start) begin
                starts++;
                start_cyc = n;
                chk("rs1_signed", mul_rs1_signed, sa);
                chk("rs2_signed", mul_rs2_signed, sb);
            end
            if (starts > 0 && !resp_valid) begin
                chk("rs1_stable", mul_rs1, a);
                chk("rs2_stable", mul_rs2, b);
            end
            if (resp_valid) got = 1'b1;
        end
        if (!got) begin
            chk("resp_never", 0, 1);
            return;
        end
        if (tmo) chk("latency_tmo", (n >= 65 && n <= 67), 1);
        else     chk("latency", n, fast ? 1 : 21);
        chk("start_pulses", starts, fast ? 0 : 1);
        if (!fast) chk("start_cycle", start_cyc, 1);
        chk("resp_data", resp_data, exp_data);
        chk("resp_err", resp_err, exp_err);
        chk("resp_rd", resp_rd, rd);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("hold_valid", resp_valid, 1);
            chk("hold_data", resp_data, exp_data);
            chk("hold_rd", resp_rd, rd);
        end
        resp_ready = 1'b1;
        flush = flush_resp;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("resp_valid_drop", resp_valid, 0);
        chk("req_ready_back", req_ready, 1);
        if (!fast && !tmo) begin
            cache_v = 1'b1; cache_a = a; cache_b = b; cache_sa = sa; cache_sb = sb;
        end
        if (flush_resp) cache_v = 1'b0;
    endtask

    task automatic flush_req(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                             input int flush_at);
        int n;
        bit back;
        @(negedge clk);
        req_valid = 1'b1; req_op_a = a; req_op_b = b; req_funct3 = f3; req_rd = 5'd9;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0; back = 1'b0;
        while (!back && n < 200) begin
            @(negedge clk);
            flush = 1'b0;
            n++;
            chk("flush_no_resp", resp_valid, 0);
            if (n >= 1 && !req_ready) begin
                chk("flush_rs1", mul_rs1, a);
                chk("flush_rs2", mul_rs2, b);
            end
            if (req_ready) back = 1'b1;
            if (n == flush_at) flush = 1'b1;
        end
        flush = 1'b0;
        chk("flush_return", n, 21);
        cache_v = 1'b0;
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_funct3 = 3'd0; req_op_a = 32'd0; req_op_b = 32'd0;
        req_rd = 5'd0; flush = 1'b0; resp_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_mul_start", mul_start, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_rd", resp_rd, 0);
        chk("rst_rs1", mul_rs1, 0);
        chk("rst_rs2", mul_rs2, 0);
        chk("rst_signed", {mul_rs1_signed, mul_rs2_signed}, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("req_ready_after_rst", req_ready, 1);

        do_req(32'h0000_0007, 32'h0000_0006, 3'b000, 5'd5, 0, 1'b0);
        do_req(32'hFFFF_FFFF, 32'h8000_0000, 3'b001, 5'd6, 1, 1'b0);
        do_req(32'hFFFF_FFFF, 32'h8000_0000, 3'b011, 5'd7, 0, 1'b0);
        do_req(32'hFFFF_FFFF, 32'h0000_0002, 3'b010, 5'd8, 2, 1'b0);
        do_req(32'h1234_5678, 32'h9ABC_DEF0, 3'b000, 5'd10, 0, 1'b0);
        do_req(32'h1234_5678, 32'h9ABC_DEF0, 3'b011, 5'd11, 0, 1'b0);
        do_req(32'h1234_5678, 32'h9ABC_DEF0, 3'b001, 5'd12, 0, 1'b0);
        do_req(32'h1234_5678, 32'h9ABC_DEF0, 3'b000, 5'd13, 1, 1'b0);
        do_req(32'hDEAD_BEEF, 32'h0000_0000, 3'b001, 5'd14, 0, 1'b0);
        do_req(32'h0000_0000, 32'h1111_1111, 3'b000, 5'd15, 0, 1'b0);
        do_req(32'hCAFE_F00D, 32'h0000_0003, 3'b100, 5'd16, 1, 1'b0);
        do_req(32'h1234_5678, 32'h9ABC_DEF0, 3'b001, 5'd17, 0, 1'b1);
        do_req(32'h1234_5678, 32'h9ABC_DEF0, 3'b001, 5'd18, 0, 1'b0);

        flush_req(32'h8765_4321, 32'h0F0F_0F0F, 3'b011, 5);
        do_req(32'h8765_4321, 32'h0F0F_0F0F, 3'b011, 5'd19, 0, 1'b0);
        flush_req(32'h0BAD_CAFE, 32'h7777_0001, 3'b001, 1);
        do_req(32'h0BAD_CAFE, 32'h7777_0001, 3'b001, 5'd20, 0, 1'b0);

        // flush while a request is offered in IDLE drops it
        @(negedge clk);
        req_valid = 1'b1; flush = 1'b1; req_op_a = 32'h5; req_op_b = 32'h6; req_funct3 = 3'b000;
        @(posedge clk);
        #1;
        req_valid = 1'b0; flush = 1'b0;
        cache_v = 1'b0;
        @(negedge clk);
        chk("idle_flush_no_resp", resp_valid, 0);
        chk("idle_flush_no_start", mul_start, 0);
        chk("idle_flush_ready", req_ready, 1);

        // reset in the middle of a multiply
        @(negedge clk);
        req_valid = 1'b1; req_op_a = 32'h1357_9BDF; req_op_b = 32'h2468_ACE0; req_funct3 = 3'b011; req_rd = 5'd21;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_req_ready", req_ready, 0);
        chk("midrst_start", mul_start, 0);
        chk("midrst_resp_valid", resp_valid, 0);
        chk("midrst_err", resp_err, 0);
        chk("midrst_data", resp_data, 0);
        chk("midrst_rd", resp_rd, 0);
        chk("midrst_rs", {mul_rs1, mul_rs2}, 0);
        chk("midrst_signed", {mul_rs1_signed, mul_rs2_signed}, 0);
        rst = 1'b1;
        cache_v = 1'b0;
        @(negedge clk);
        chk("midrst_ready_back", req_ready, 1);
        repeat (25) @(negedge clk);

        // multiplier that never goes busy
        never_busy = 1'b1;
        do_req(32'h3333_3333, 32'h4444_4444, 3'b001, 5'd22, 0, 1'b0);
        never_busy = 1'b0;
        repeat (25) @(negedge clk);

        for (int k = 0; k < 30; k++) begin
            logic [31:0] a, b;
            logic [2:0]  f3;
            int kind;
            kind = $urandom_range(0, 9);
            a = $urandom;
            b = $urandom;
            if (kind == 0)      b = 32'd0;
            else if (kind == 1) a = 32'd0;
            else if (kind <= 4) begin a = last_a; b = last_b; end
            f3 = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            if (a != 32'd0 && b != 32'd0) begin last_a = a; last_b = b; end
            do_req(a, b, f3, 5'($urandom), $urandom_range(0, 2), ($urandom_range(0, 9) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
